// File: rtl/ctrl_pkg.sv
// Shared definitions for the block transfer sequencer: FSM state encoding,
// transfer stride, addressing-mode codes and a register-list popcount.
package ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned WORD_BYTES = 4;

  // Addressing modes encoded as {pre, up}
  localparam logic [1:0] MODE_DA = 2'b00;
  localparam logic [1:0] MODE_IA = 2'b01;
  localparam logic [1:0] MODE_DB = 2'b10;
  localparam logic [1:0] MODE_IB = 2'b11;

  // Number of registers selected in a 16-bit list (0..16)
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/lowest_set_bit_encoder.sv
// Fixed-priority encoder: index of the lowest set bit of a 16-bit vector.
// Ports: vec (in, 16) ; idx (out, 4) lowest set bit index ; valid (out) any bit set.
module lowest_set_bit_encoder (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        valid
);

  logic [7:0] half8;
  logic [3:0] half4;
  logic [1:0] half2;

  // Binary search: at each level pick the lower half if it holds any set bit
  always_comb begin
    idx[3] = ~|vec[7:0];
    half8  = idx[3] ? vec[15:8] : vec[7:0];
    idx[2] = ~|half8[3:0];
    half4  = idx[2] ? half8[7:4] : half8[3:0];
    idx[1] = ~|half4[1:0];
    half2  = idx[1] ? half4[3:2] : half4[1:0];
    idx[0] = ~half2[0];
    valid  = |vec;
  end

endmodule

// File: rtl/block_transfer_sequencer.sv
// Load/store-multiple sequencer. Walks a captured 16-bit register list from the
// lowest register upward, issuing one memory access per selected register at
// ascending word addresses, and produces the base-register writeback value.
// Ports:
//   clk, reset_n                   clock, async active-low reset
//   start, reg_list, base_addr     request and operands (sampled in IDLE only)
//   load, up, pre, writeback       transfer direction / addressing mode / base update
//   mem_ready                      memory completes the current access
//   reg_addr, mem_addr             register and word address of current access
//   mem_req, mem_rw                access request and direction (1 = read)
//   reg_we                         register-file write strobe for load data
//   wb_we, wb_value                base writeback strobe and value
//   busy, done                     activity flag and one-cycle completion pulse
module block_transfer_sequencer #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WORD_BYTES = ctrl_pkg::WORD_BYTES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       reg_list,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              load,
  input  logic              up,
  input  logic              pre,
  input  logic              writeback,
  input  logic              mem_ready,
  output logic [3:0]        reg_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  output logic              mem_rw,
  output logic              reg_we,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_value,
  output logic              busy,
  output logic              done
);

  import ctrl_pkg::*;

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

  state_t            state_q, state_d;
  logic [15:0]       list_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [ADDR_W-1:0] wb_value_q;
  logic [4:0]        n_q;
  logic              load_q, up_q, pre_q, wb_q;

  logic [4:0]        n_c;
  logic [ADDR_W-1:0] span_c;
  logic [ADDR_W-1:0] first_addr_c;
  logic [15:0]       list_rest_c;
  logic              last_c;
  logic [3:0]        lsb_idx;
  logic              lsb_valid;

  lowest_set_bit_encoder u_lsb (
    .vec   (list_q),
    .idx   (lsb_idx),
    .valid (lsb_valid)
  );

  // Setup arithmetic and lowest-bit clear (x & (x-1) drops the lowest set bit)
  always_comb begin
    n_c         = popcount16(list_q);
    span_c      = ADDR_W'(n_c) * STRIDE;
    list_rest_c = list_q & 16'(list_q - 16'd1);
    last_c      = (list_rest_c == 16'd0);
    unique case ({pre_q, up_q})
      MODE_IA: first_addr_c = base_q;
      MODE_IB: first_addr_c = base_q + STRIDE;
      MODE_DA: first_addr_c = base_q - span_c + STRIDE;
      default: first_addr_c = base_q - span_c;  // MODE_DB
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Captured operands, walking list and current address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      list_q     <= '0;
      base_q     <= '0;
      cur_addr_q <= '0;
      wb_value_q <= '0;
      n_q        <= '0;
      load_q     <= 1'b0;
      up_q       <= 1'b0;
      pre_q      <= 1'b0;
      wb_q       <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            list_q <= reg_list;
            base_q <= base_addr;
            load_q <= load;
            up_q   <= up;
            pre_q  <= pre;
            wb_q   <= writeback;
          end
        end
        ST_SETUP: begin
          n_q        <= n_c;
          cur_addr_q <= first_addr_c;
          wb_value_q <= up_q ? (base_q + span_c) : (base_q - span_c);
        end
        ST_XFER: begin
          if (mem_ready) begin
            list_q     <= list_rest_c;
            cur_addr_q <= cur_addr_q + STRIDE;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and output decode
  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    mem_req  = 1'b0;
    mem_rw   = 1'b0;
    reg_we   = 1'b0;
    reg_addr = '0;
    mem_addr = '0;
    done     = 1'b0;
    wb_we    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        busy    = 1'b1;
        state_d = (n_c == 5'd0) ? ST_DONE : ST_XFER;
      end
      ST_XFER: begin
        busy = 1'b1;
        if (lsb_valid) begin
          mem_req  = 1'b1;
          mem_rw   = load_q;
          reg_addr = lsb_idx;
          mem_addr = cur_addr_q;
          reg_we   = load_q & mem_ready;
        end
        if (mem_ready && last_c) state_d = ST_DONE;
      end
      default: begin  // ST_DONE
        busy    = 1'b1;
        done    = 1'b1;
        wb_we   = wb_q & (n_q != 5'd0);
        state_d = ST_IDLE;
      end
    endcase
  end

  assign wb_value = wb_value_q;

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Self-checking bench for block_transfer_sequencer: reset sequences plus a
// table of transfers whose expected accesses are queued at start and popped
// as the sequencer completes each memory handshake.
module tb_block_transfer_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic        load, up, pre, writeback, mem_ready;
  logic [3:0]  reg_addr;
  logic [31:0] mem_addr;
  logic        mem_req, mem_rw, reg_we, wb_we;
  logic [31:0] wb_value;
  logic        busy, done;

  int total = 0;
  int bad   = 0;

  block_transfer_sequencer #(.ADDR_W(32), .WORD_BYTES(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .reg_list  (reg_list),
    .base_addr (base_addr),
    .load      (load),
    .up        (up),
    .pre       (pre),
    .writeback (writeback),
    .mem_ready (mem_ready),
    .reg_addr  (reg_addr),
    .mem_addr  (mem_addr),
    .mem_req   (mem_req),
    .mem_rw    (mem_rw),
    .reg_we    (reg_we),
    .wb_we     (wb_we),
    .wb_value  (wb_value),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] list;
    logic [31:0] base;
    logic        load;
    logic        up;
    logic        pre;
    logic        wb;
    int          delay;
    bit          restart;
    logic [31:0] exp_wbv;
    logic        exp_wbwe;
  } vec_t;

  typedef struct packed {
    logic [3:0]  r;
    logic [31:0] a;
    logic        rw;
  } acc_t;

  acc_t exp_q[$];
  vec_t vecs[7];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [79:0] all_out();
    return {6'b0, reg_addr, mem_addr, mem_req, mem_rw, reg_we, wb_we, wb_value, busy, done};
  endfunction

  task automatic run_vec(input vec_t v);
    int n, k, c, waitc;
    logic [31:0] lo;
    logic [3:0]  pr;
    logic [31:0] pa;
    bit waiting, seen_done;
    acc_t e;
    n = 0;
    for (int i = 0; i < 16; i++) if (v.list[i]) n++;
    if (v.up) lo = v.pre ? v.base + 32'd4 : v.base;
    else      lo = v.pre ? v.base - 32'(4 * n) : v.base - 32'(4 * n) + 32'd4;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (v.list[i]) begin
        exp_q.push_back('{r: 4'(i), a: lo + 32'(4 * k), rw: v.load});
        k++;
      end
    end
    @(negedge clk);
    start = 1'b1; reg_list = v.list; base_addr = v.base;
    load = v.load; up = v.up; pre = v.pre; writeback = v.wb; mem_ready = 1'b0;
    @(negedge clk);
    // operands must already be captured; scramble the inputs
    start = 1'b0; reg_list = 16'hA5A5; base_addr = 32'hDEAD0000;
    load = ~v.load; up = ~v.up; pre = ~v.pre; writeback = ~v.wb;
    #1 check("setup_cycle", {busy, mem_req, done}, 3'b100);
    c = 1; waitc = 0; waiting = 0; seen_done = 0; pr = '0; pa = '0;
    while (!seen_done && c < 200) begin
      @(negedge clk);
      c++;
      if (v.restart && c == 3) begin
        start = 1'b1; reg_list = 16'hFFFF; base_addr = 32'h8000;
      end else begin
        start = 1'b0;
      end
      mem_ready = mem_req && (waitc == v.delay);
      #1;
      if (mem_req) begin
        if (waiting) check("hold_stable", {reg_addr, mem_addr}, {pr, pa});
        pr = reg_addr; pa = mem_addr;
        if (mem_ready) begin
          if (exp_q.size() == 0) check("extra_access", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("access", {reg_addr, mem_addr, mem_rw, reg_we}, {e.r, e.a, e.rw, e.rw});
          end
          waiting = 0; waitc = 0;
        end else begin
          check("wait_strobes", {reg_we, mem_rw}, {1'b0, v.load});
          waiting = 1; waitc++;
        end
      end
      if (done) begin
        seen_done = 1;
        check("done_cycle", 80'(c), 80'(2 + n * (v.delay + 1)));
        check("done_out", {wb_we, wb_value, mem_req, reg_we, busy},
              {v.exp_wbwe, v.exp_wbv, 1'b0, 1'b0, 1'b1});
        check("queue_drained", 80'(exp_q.size()), 80'(0));
      end
    end
    if (!seen_done) check("timeout", 1, 0);
    mem_ready = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check("idle_after", {busy, done, mem_req, wb_we, reg_we}, 5'b0);
    end
    exp_q.delete();
  endtask

  initial begin
    //          list      base          ld    up    pre   wb    dly rst   exp_wbv       wbwe
    vecs[0] = '{16'h8005, 32'h00000100, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, 32'h0000010C, 1'b1};
    vecs[1] = '{16'h00F0, 32'h00000200, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b0, 32'h000001F0, 1'b1};
    vecs[2] = '{16'h0000, 32'h00000300, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, 32'h00000300, 1'b0};
    vecs[3] = '{16'h0003, 32'hFFFFFFF8, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0, 32'h00000000, 1'b1};
    vecs[4] = '{16'h0210, 32'h00001002, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 32'h00000FFA, 1'b0};
    vecs[5] = '{16'h0C01, 32'h00000040, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b1, 32'h0000004C, 1'b1};
    vecs[6] = '{16'hFFFF, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0, 32'h00000040, 1'b1};

    // start held during reset must be ignored
    reset_n = 1'b0; start = 1'b1; reg_list = 16'hFFFF; base_addr = 32'h1234;
    load = 1'b1; up = 1'b1; pre = 1'b0; writeback = 1'b1; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", all_out(), 80'b0);
    @(negedge clk);
    reset_n = 1'b1; start = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    #1 check("idle_after_reset", all_out(), 80'b0);

    // reset in the middle of a transfer aborts at once
    @(negedge clk);
    start = 1'b1; reg_list = 16'hFFFF; base_addr = 32'h500; mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("mid_xfer_active", {mem_req, reg_we}, 2'b11);
    reset_n = 1'b0;
    #1 check("mid_reset_outputs", all_out(), 80'b0);
    @(negedge clk);
    #1 check("mid_reset_hold", all_out(), 80'b0);
    reset_n = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    #1 check("post_abort_idle", all_out(), 80'b0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
